// File: rtl/pmp_scan_checker_pkg.sv
// PMP types shared by the serial permission checker and its entry matcher.
package pmp_scan_checker_pkg;

  localparam int unsigned XLEN = 32;

  // Address-matching mode of a PMP entry (pmpcfg.A)
  typedef enum logic [1:0] {
    PMP_OFF   = 2'b00,
    PMP_TOR   = 2'b01,
    PMP_NA4   = 2'b10,
    PMP_NAPOT = 2'b11
  } pmp_mode_t;

  // One pmpcfg byte, MSB first: L, reserved, A, X, W, R
  typedef struct packed {
    logic      l;
    logic [1:0] rsvd;
    pmp_mode_t a;
    logic      x;
    logic      w;
    logic      r;
  } pmpcfg_base_t;

  // pmpaddr holds physical address bits [33:2]
  typedef logic [XLEN-1:0] pmpaddr_t;

  typedef enum logic [1:0] {
    ACC_R,
    ACC_W,
    ACC_X
  } pmp_access_t;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    RESP
  } pmp_scan_state_t;

  typedef enum logic {
    PORT_IF,
    PORT_D
  } pmp_port_t;

endpackage

// File: rtl/pmp_entry_match.sv
// Combinational address match of one PMP entry against a word address.
module pmp_entry_match
  import pmp_scan_checker_pkg::*;
(
  input  pmpcfg_base_t    cfg,
  input  pmpaddr_t        addr_i,
  input  pmpaddr_t        addr_prev,
  input  logic [XLEN-1:0] a,
  output logic            match
);

  logic [XLEN-1:0] napot_mask;
  logic            unused_cfg;

  // Only the mode field selects the match rule; permissions are applied upstream
  assign unused_cfg = ^{cfg.l, cfg.rsvd, cfg.x, cfg.w, cfg.r};

  // addr ^ (addr+1) sets the trailing-ones run plus the next bit; all-ones gives mask 0
  always_comb begin
    napot_mask = ~(addr_i ^ (addr_i + XLEN'(1)));
    match      = 1'b0;
    unique case (cfg.a)
      PMP_OFF:   match = 1'b0;
      PMP_TOR:   match = (a >= addr_prev) && (a < addr_i);
      PMP_NA4:   match = (a == addr_i);
      PMP_NAPOT: match = ((a & napot_mask) == (addr_i & napot_mask));
      default:   match = 1'b0;
    endcase
  end

endmodule

// File: rtl/pmp_scan_checker.sv
// Serial PMP checker: round-robin between fetch and data, one entry scanned per cycle.
module pmp_scan_checker
  import pmp_scan_checker_pkg::*;
#(
  parameter int unsigned NUM_ENTRIES = 16
) (
  input  logic                     CLK,
  input  logic                     nRST,
  input  logic [NUM_ENTRIES*8-1:0]  pmpcfg_regs,
  input  logic [NUM_ENTRIES*32-1:0] pmpaddr_regs,
  input  logic                     cfg_wr,
  input  logic                     priv_m,
  input  logic                     if_req,
  input  logic [31:0]              if_addr,
  output logic                     if_done,
  output logic                     if_fault,
  input  logic                     d_req,
  input  logic [31:0]              d_addr,
  input  logic                     d_wen,
  output logic                     d_done,
  output logic                     d_fault,
  output logic                     busy
);

  localparam int unsigned IDX_W = $clog2(NUM_ENTRIES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ENTRIES - 1);

  pmpcfg_base_t    cfg_arr  [NUM_ENTRIES];
  pmpaddr_t        addr_arr [NUM_ENTRIES];

  pmp_scan_state_t state_q;
  logic [IDX_W-1:0] idx_q;
  pmp_port_t       port_q;
  pmp_port_t       last_grant_q;
  pmp_access_t     acc_q;
  logic [31:0]     a_q;
  logic            priv_q;
  logic            if_done_q, if_fault_q, d_done_q, d_fault_q, busy_q;

  pmpcfg_base_t    cfg_sel;
  pmpaddr_t        addr_sel;
  pmpaddr_t        addr_prev;
  logic            entry_match;
  logic            perm;
  logic            result_fault;
  logic            granted_req;
  logic            unused_bits;

  // Unpack the flat CSR buses into per-entry views
  for (genvar g = 0; g < NUM_ENTRIES; g++) begin : g_unpack
    assign cfg_arr[g]  = pmpcfg_base_t'(pmpcfg_regs[8*g +: 8]);
    assign addr_arr[g] = pmpaddr_regs[32*g +: 32];
  end

  // Byte offset bits are irrelevant for word-granular checks
  assign unused_bits = ^{if_addr[1:0], d_addr[1:0], cfg_sel.rsvd};

  // Select the entry under scan and derive its permission result
  always_comb begin
    cfg_sel     = cfg_arr[idx_q];
    addr_sel    = addr_arr[idx_q];
    addr_prev   = (idx_q == '0) ? '0 : addr_arr[idx_q - IDX_W'(1)];
    granted_req = (port_q == PORT_IF) ? if_req : d_req;
    perm        = 1'b0;
    unique case (acc_q)
      ACC_R:   perm = cfg_sel.r;
      ACC_W:   perm = cfg_sel.w & cfg_sel.r;
      ACC_X:   perm = cfg_sel.x;
      default: perm = 1'b0;
    endcase
    if (entry_match) begin
      result_fault = (priv_q && !cfg_sel.l) ? 1'b0 : !perm;
    end else begin
      result_fault = !priv_q;
    end
  end

  pmp_entry_match u_match (
    .cfg       (cfg_sel),
    .addr_i    (addr_sel),
    .addr_prev (addr_prev),
    .a         (a_q),
    .match     (entry_match)
  );

  // Arbitration, serial scan and registered response
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      port_q       <= PORT_IF;
      last_grant_q <= PORT_D;
      acc_q        <= ACC_R;
      a_q          <= '0;
      priv_q       <= 1'b0;
      if_done_q    <= 1'b0;
      if_fault_q   <= 1'b0;
      d_done_q     <= 1'b0;
      d_fault_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      if_done_q  <= 1'b0;
      if_fault_q <= 1'b0;
      d_done_q   <= 1'b0;
      d_fault_q  <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (if_req && (!d_req || last_grant_q == PORT_D)) begin
            port_q  <= PORT_IF;
            a_q     <= {2'b00, if_addr[31:2]};
            acc_q   <= ACC_X;
            priv_q  <= priv_m;
            idx_q   <= '0;
            state_q <= SCAN;
            busy_q  <= 1'b1;
          end else if (d_req) begin
            port_q  <= PORT_D;
            a_q     <= {2'b00, d_addr[31:2]};
            acc_q   <= d_wen ? ACC_W : ACC_R;
            priv_q  <= priv_m;
            idx_q   <= '0;
            state_q <= SCAN;
            busy_q  <= 1'b1;
          end
        end
        SCAN: begin
          if (!granted_req) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else if (cfg_wr) begin
            idx_q <= '0;
          end else if (entry_match || idx_q == LAST_IDX) begin
            state_q <= RESP;
            if (port_q == PORT_IF) begin
              if_done_q  <= 1'b1;
              if_fault_q <= result_fault;
            end else begin
              d_done_q  <= 1'b1;
              d_fault_q <= result_fault;
            end
          end else begin
            idx_q <= idx_q + IDX_W'(1);
          end
        end
        RESP: begin
          last_grant_q <= port_q;
          state_q      <= IDLE;
          busy_q       <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign if_done  = if_done_q;
  assign if_fault = if_fault_q;
  assign d_done   = d_done_q;
  assign d_fault  = d_fault_q;
  assign busy     = busy_q;

endmodule

// File: doc/pmp_scan_checker.md
Name: pmp_scan_checker

Overview:
- Area-optimised, multi-cycle PMP permission checker for RV32.
- Arbitrates two requesters, instruction fetch and data, then scans the PMP entries serially, one entry per cycle, lowest index first, stopping at the first match.
- Sits between the CSR file, which supplies the live pmpcfg/pmpaddr values, and the fetch/memory stages, which stall until `*_done`.

Parameters:
- NUM_ENTRIES, 16, number of implemented PMP entries; multiple of 4, range 4..64.
- IDX_W, $clog2(NUM_ENTRIES), scan index width (derived).

Ports:
- CLK  in  1  clock.
- nRST  in  1  asynchronous active-low reset.
- pmpcfg_regs  in  NUM_ENTRIES*8  packed pmpcfg_t words; entry i config is at bits [8i+7:8i].
- pmpaddr_regs  in  NUM_ENTRIES*32  entry i at bits [32i+31:32i]; holds address bits [33:2].
- cfg_wr  in  1  pulse: any pmpcfg/pmpaddr CSR written this cycle.
- priv_m  in  1  requester is running in M-mode (shared by both ports).
- if_req  in  1  fetch check request; held until if_done.
- if_addr  in  32  fetch byte address.
- if_done  out  1  one-cycle pulse: fetch result valid.
- if_fault  out  1  fetch denied; valid with if_done.
- d_req  in  1  data check request; held until d_done.
- d_addr  in  32  data byte address.
- d_wen  in  1  1 = store check, 0 = load check.
- d_done  out  1  one-cycle pulse: data result valid.
- d_fault  out  1  data denied; valid with d_done.
- busy  out  1  FSM not IDLE.

Behaviour:
- All outputs registered. Reset values: if_done, if_fault, d_done, d_fault, busy = 0; state = IDLE; idx = 0; last_grant = DATA, so fetch wins first.
- FSM states: IDLE, SCAN, RESP.
- IDLE:
  - If exactly one req is high, grant it.
  - If both are high, grant the requester not recorded in last_grant (round-robin).
  - On grant: latch port select, word address a = {2'b00, addr[31:2]}, access type (X for fetch; R or W for data per d_wen), and priv_m. Set idx = 0 and go to SCAN.
- SCAN: evaluate entry idx against the latched request.
  - If it matches, latch the permission result and go to RESP.
  - If it does not match and idx == NUM_ENTRIES-1, latch the no-match result and go to RESP.
  - Otherwise increment idx.
- RESP: assert the granted port's done for exactly one cycle, with fault valid in the same cycle. Update last_grant and return to IDLE.
- Latency: a req first seen in IDLE at cycle T has done at cycle T+j+2, where j is the first matching index, or NUM_ENTRIES-1 if none matches. Worst case is NUM_ENTRIES+1 cycles.
- Back-to-back: IDLE is re-entered after RESP, so a held req is regranted the cycle after done.
- Match rules, with A the entry mode:
  - OFF: never matches.
  - NA4: a == pmpaddr[i].
  - TOR: lo <= a < pmpaddr[i], unsigned 32-bit compare, with lo = pmpaddr[i-1] (lo = 0 for i = 0). If lo >= pmpaddr[i], the entry never matches.
  - NAPOT: with k = number of trailing ones of pmpaddr[i], mask = ~((1 << (k+1)) - 1), and the entry matches when (a & mask) == (pmpaddr[i] & mask). All-ones pmpaddr matches every address.
- Accesses are word-granular and naturally aligned; partial-match handling is not required.
- Permission result:
  - Matched entry with priv_m = 1 and L = 0: allow.
  - Otherwise: fault = ~perm, where perm is the entry's X, R or W bit for the latched access type.
  - Reserved combination R=0, W=1 is treated as R=0, W=0.
- No-match result: allow if priv_m = 1, fault if priv_m = 0.
- cfg_wr during SCAN: restart the scan at idx = 0 next cycle; the latched request is kept. cfg_wr in IDLE or RESP has no effect; a result already latched in RESP stands.
- Granted req deasserted during SCAN: abort to IDLE, emit no done, leave last_grant unchanged. The non-granted req never aborts anything.
- nRST asserted mid-operation: immediately return to the reset values; any pending check is dropped and no done is emitted.

Decomposition:
- Add to the PMP types package:
  - pmp_access_t enum {ACC_R, ACC_W, ACC_X}
  - pmp_scan_state_t enum {IDLE, SCAN, RESP}
  - pmp_port_t enum {PORT_IF, PORT_D}
- The existing pmp_mode_t, pmpcfg_base_t and pmpaddr_t are reused from that package.
- One combinational sub-module, pmp_entry_match. Inputs: pmpcfg_base_t cfg, pmpaddr_t addr_i, pmpaddr_t addr_prev, 32-bit a. Output: match. It is instantiated once and driven by the idx-selected entry.

Test Plan:
- Reset, no requests -> all outputs 0 and busy = 0. Assert nRST low mid-SCAN -> busy drops asynchronously and no done is emitted.
- Entry 0 NAPOT, pmpaddr = 0x0000_01FF, cfg R=1 L=1; d_req load at 0x0000_0400, priv_m = 0 -> d_done at T+2 with d_fault = 0. Repeat as a store -> d_fault = 1.
- Entry 3 TOR with pmpaddr[2] = 0x100 and pmpaddr[3] = 0x200, X=1, entries 0..2 OFF; if_req at 0x0000_07FC -> if_done at T+5, if_fault = 0. Fetch at 0x0000_0800 -> no match, priv_m = 0 -> if_fault = 1, if_done at T+NUM_ENTRIES+1.
- M-mode: matching NA4 entry with L=0 and RWX=000 -> no fault. Set L=1 -> fault. No-match in M-mode -> no fault.
- if_req and d_req both held continuously -> grants alternate fetch, data, fetch, data, with fetch first after reset; each done pulse is exactly 1 cycle.
- Pulse cfg_wr at scan idx 2 while matching entry 5 -> done at T+10 instead of T+7. Drop d_req mid-SCAN -> no d_done, and busy = 0 the next cycle.
